pc_sequencer: RTL

Parametrised program-counter and pipeline-sequencing block for the in-order pipelined CPU core. It owns the PC, the registered condition-flag set, the eight-way branch-condition evaluation, and per-stage valid tracking. It also generates flushes on taken branches and runs a halt drain sequence. It sits beside instruction memory and supplies the fetch address and valid bits to every pipeline register downstream of fetch.

---
 rtl/pc_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program counter, condition flags, branch evaluation and per-stage valid tracking
// for the in-order pipeline, including taken-branch flush and the halt drain sequence.
module pc_sequencer #(
  parameter int PC_W      = 16,
  parameter int OFF_W     = 9,
  parameter int OFF_SHIFT = 2,
  parameter int PC_INC    = 4,
  parameter int STAGES    = 4,
  parameter int BR_STAGE  = 2,
  parameter int RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flags_we,
  input  logic [2:0]        flags_in,
  input  logic              br_valid,
  input  logic [2:0]        br_cond,
  input  logic [PC_W-1:0]   br_base,
  input  logic [OFF_W-1:0]  br_off,
  input  logic              hlt_req,
  output logic [PC_W-1:0]   pc,
  output logic              fetch_valid,
  output logic [STAGES-1:0] stage_valid,
  output logic              taken,
  output logic              flush,
  output logic              hlt
);

  localparam int              CNT_W     = $clog2(STAGES);
  localparam logic [CNT_W-1:0] DRAIN_CNT = CNT_W'(STAGES - 1 - BR_STAGE);
  localparam logic [PC_W-1:0] PC_STEP   = PC_W'(PC_INC);
  localparam logic [PC_W-1:0] PC_RST    = PC_W'(RESET_PC);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [PC_W-1:0]     pc_nxt;
  logic [STAGES-1:0]   sv_nxt, flushed_sv;
  logic [2:0]          flags;
  logic                n_f, v_f, z_f;
  logic                cond_met, run, br_q, hlt_q;
  logic [PC_W-1:0]     off_ext, target;

  assign {n_f, v_f, z_f} = flags;

  // Conditions look only at the registered flags, never at same-cycle flags_in.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cond_met = 1'b1;
    case (br_cond)
      3'b000:  cond_met = !z_f;
      3'b001:  cond_met = z_f;
      3'b010:  cond_met = !(z_f | n_f);
      3'b011:  cond_met = n_f;
      3'b100:  cond_met = z_f | !n_f;
      3'b101:  cond_met = n_f | z_f;
      3'b110:  cond_met = v_f;
      default: cond_met = 1'b1;
    endcase
  end

  assign run         = (state == RUN);
  assign br_q        = run & br_valid & stage_valid[BR_STAGE];
  assign hlt_q       = run & hlt_req & stage_valid[BR_STAGE];
  assign taken       = br_q & ~hlt_q & cond_met;
  assign flush       = taken | hlt_q;
  assign fetch_valid = run & ~flush;
  assign hlt         = (state == HALTED);

  assign off_ext = PC_W'($signed(br_off));
  assign target  = br_base + (off_ext << OFF_SHIFT);

  // Squash stages up to the resolving one; the branch/halt itself moves on.
  always_comb begin
    flushed_sv = '0;
    for (int i = BR_STAGE + 1; i < STAGES; i++)
      flushed_sv[i] = (i == BR_STAGE + 1) ? 1'b1 : stage_valid[i-1];
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_nxt    = pc;
    sv_nxt    = stage_valid;
    case (state)
      RUN: begin
        if (hlt_q) begin
          state_nxt = DRAIN;
          cnt_nxt   = DRAIN_CNT;
          sv_nxt    = flushed_sv;
        end else if (taken) begin
          pc_nxt = target;
          sv_nxt = flushed_sv;
        end else if (stall) begin
          sv_nxt    = {stage_valid[STAGES-2:0], stage_valid[0]};
          sv_nxt[1] = 1'b0;
        end else begin
          pc_nxt = pc + PC_STEP;
          sv_nxt = {stage_valid[STAGES-2:0], 1'b1};
        end
      end
      DRAIN: begin
        sv_nxt  = {stage_valid[STAGES-2:0], 1'b0};
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt_nxt == '0) state_nxt = HALTED;
      end
      HALTED:  sv_nxt = '0;
      default: state_nxt = RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      cnt         <= '0;
      pc          <= PC_RST;
      stage_valid <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pc          <= pc_nxt;
      stage_valid <= sv_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      flags <= 3'b000;
    else if (flags_we && !hlt)       flags <= flags_in;
  end

endmodule
